frame_buffer_pipelined: RTL and testbench

- Parametrised successor to the 800x480 1-bpp frame buffer.
- Maps VGA scan coordinates to packed-word RAM addresses with the correct row-major formula, v*WORDS_PER_LINE + h/PPW.
- Delivers pixels through a fixed 2-cycle registered read pipeline with an aligned active flag.
- Adds a write port with a ready handshake and a hardware clear/fill engine. Sits between the VGA timing generator and the drawing logic.

---
 rtl/frame_buffer_pipelined.sv | 145 ++++++++++++++
 tb/tb_frame_buffer_pipelined.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pipelined.sv
// Packed-word frame buffer: maps VGA scan coordinates to RAM words through a
// fixed 2-cycle read pipeline, with a handshaked write port and a clear/fill engine.
`timescale 1ns/1ps
module frame_buffer_pipelined #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BPP      = 1,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned COORD_W  = 11,
  localparam int unsigned PPW            = WORD_W / BPP,
  localparam int unsigned WORDS_PER_LINE = H_ACTIVE / PPW,
  localparam int unsigned DEPTH          = WORDS_PER_LINE * V_ACTIVE,
  localparam int unsigned ADDR_W         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] vga_h,
  input  logic [COORD_W-1:0] vga_v,
  output logic [BPP-1:0]     pixel_out,
  output logic               pixel_active,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  output logic               wr_ready,
  input  logic               clear_req,
  input  logic [BPP-1:0]     clear_color,
  output logic               busy,
  output logic               clear_done
);

  localparam int unsigned K_W = (PPW > 1) ? $clog2(PPW) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_word;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic [WORD_W-1:0] r_fill;
  logic [WORD_W-1:0] w_fill_nxt;
  logic              r_clear_done;
  logic              w_clear_done_nxt;

  logic              w_inside;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [K_W-1:0]    w_k;
  logic [K_W-1:0]    r_k1;
  logic              r_in1;

  logic              w_user_wr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [WORD_W-1:0] w_mem_wdata;

  // Stage 0: visibility test and row-major word address; off-screen reads hit address 0
  always_comb begin
    w_inside  = (32'(vga_h) < H_ACTIVE) && (32'(vga_v) < V_ACTIVE);
    w_rd_addr = '0;
    w_k       = '0;
    if (w_inside) begin
      w_rd_addr = ADDR_W'(32'(vga_v) * WORDS_PER_LINE + 32'(vga_h) / PPW);
      w_k       = K_W'(32'(vga_h) % PPW);
    end
  end

  // Write arbitration: the clear engine owns the write port while running
  always_comb begin
    w_user_wr   = wr_en && (r_state == S_IDLE) && (32'(wr_addr) < DEPTH);
    w_mem_we    = (r_state == S_CLEAR) || w_user_wr;
    w_mem_waddr = (r_state == S_CLEAR) ? r_clr_addr : wr_addr;
    w_mem_wdata = (r_state == S_CLEAR) ? r_fill : wr_data;
  end

  // RAM is not reset; a same-address read returns the pre-write word
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
    r_rd_word <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_clr_addr   <= '0;
      r_fill       <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_addr   <= w_clr_addr_nxt;
      r_fill       <= w_fill_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_clr_addr_nxt   = r_clr_addr;
    w_fill_nxt       = r_fill;
    w_clear_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
          w_fill_nxt     = {PPW{clear_color}};
        end
      end
      S_CLEAR: begin
        if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt      = S_IDLE;
          w_clr_addr_nxt   = '0;
          w_clear_done_nxt = 1'b1;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stages 1-2: delay pixel index and visibility alongside the RAM read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k1         <= '0;
      r_in1        <= 1'b0;
      pixel_out    <= '0;
      pixel_active <= 1'b0;
    end else begin
      r_k1         <= w_k;
      r_in1        <= w_inside;
      pixel_active <= r_in1;
      pixel_out    <= r_in1 ? r_rd_word[32'(r_k1) * BPP +: BPP] : '0;
    end
  end

  assign wr_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_CLEAR);
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_frame_buffer_pipelined.sv
// Self-checking bench for frame_buffer_pipelined: vector tables through a
// latency scoreboard plus hand sequences for clear, reset-mid-clear and BPP=4.
`timescale 1ns/1ps
module tb_frame_buffer_pipelined;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [10:0] vga_h, vga_v;
  logic [0:0]  pixel_out;
  logic        pixel_active;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        clear_req;
  logic [0:0]  clear_color;
  logic        busy;
  logic        clear_done;

  logic [10:0] vga_h4, vga_v4;
  logic [3:0]  pixel_out4;
  logic        pixel_active4;
  logic        wr_en4;
  logic [16:0] wr_addr4;
  logic [15:0] wr_data4;
  logic        wr_ready4;
  logic        clear_req4;
  logic [3:0]  clear_color4;
  logic        busy4;
  logic        clear_done4;

  always #5 clk = ~clk;

  frame_buffer_pipelined dut (
    .clk(clk), .reset_n(reset_n), .vga_h(vga_h), .vga_v(vga_v),
    .pixel_out(pixel_out), .pixel_active(pixel_active),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done)
  );

  frame_buffer_pipelined #(.BPP(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .vga_h(vga_h4), .vga_v(vga_v4),
    .pixel_out(pixel_out4), .pixel_active(pixel_active4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_ready(wr_ready4),
    .clear_req(clear_req4), .clear_color(clear_color4),
    .busy(busy4), .clear_done(clear_done4)
  );

  typedef struct {
    logic [7:0] pix;
    logic       act;
    int         due;
    int         id;
  } exp_t;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] pix;
    logic       act;
  } vec_t;

  exp_t sb[$];
  exp_t sb4[$];
  vec_t vecs[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int vec_id = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance one cycle and retire every scoreboard entry that has come due
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("pix#%0d", e.id), 32'(pixel_out), 32'(e.pix));
      chk($sformatf("act#%0d", e.id), 32'(pixel_active), 32'(e.act));
    end
    while (sb4.size() > 0 && sb4[0].due <= cyc) begin
      e = sb4.pop_front();
      chk($sformatf("pix4#%0d", e.id), 32'(pixel_out4), 32'(e.pix));
      chk($sformatf("act4#%0d", e.id), 32'(pixel_active4), 32'(e.act));
    end
  endtask

  task automatic present(input bit four, input int h, input int v,
                         input logic [7:0] pix, input logic act);
    exp_t e;
    e.pix = pix; e.act = act; e.due = cyc + 2; e.id = vec_id++;
    if (four) begin
      vga_h4 = 11'(h); vga_v4 = 11'(v); sb4.push_back(e);
    end else begin
      vga_h = 11'(h); vga_v = 11'(v); sb.push_back(e);
    end
    tick();
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) tick();
    chk("sb_drained", 32'(sb.size() + sb4.size()), 32'd0);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) present(1'b0, vecs[i].h, vecs[i].v, vecs[i].pix, vecs[i].act);
    flush();
    vecs.delete();
  endtask

  task automatic add_vec(input int h, input int v, input logic [7:0] pix, input logic act);
    vec_t x;
    x.h = h; x.v = v; x.pix = pix; x.act = act;
    vecs.push_back(x);
  endtask

  task automatic write_word(input logic [14:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    chk("wr_ready_idle", 32'(wr_ready), 32'd1);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_cnt, rdy_bad;
    reset_n = 1'b0;
    vga_h = '0; vga_v = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
    vga_h4 = '0; vga_v4 = '0; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;
    clear_req4 = 1'b0; clear_color4 = '0;

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    chk("rst_act", 32'(pixel_active), 32'd0);
    chk("rst_pix", 32'(pixel_out), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Basic mapping, corner word and off-screen coordinates
    write_word(15'd0, 16'h0001);
    write_word(15'd23999, 16'h8000);
    write_word(15'd50, 16'h00F0);
    add_vec(0, 0, 8'd1, 1'b1);
    add_vec(1, 0, 8'd0, 1'b1);
    add_vec(799, 479, 8'd1, 1'b1);
    add_vec(784, 479, 8'd0, 1'b1);
    add_vec(4, 1, 8'd1, 1'b1);
    add_vec(3, 1, 8'd0, 1'b1);
    add_vec(7, 1, 8'd1, 1'b1);
    add_vec(8, 1, 8'd0, 1'b1);
    add_vec(800, 0, 8'd0, 1'b0);
    add_vec(0, 480, 8'd0, 1'b0);
    add_vec(0, 0, 8'd1, 1'b1);
    run_vecs();

    // Full clear to colour 1; colour change, user write and re-request mid-clear must be ignored
    clear_color = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0; done_cnt = 0; rdy_bad = 0;
    while (busy === 1'b1 && n < 30000) begin
      if (wr_ready !== 1'b0) rdy_bad++;
      if (clear_done === 1'b1) done_cnt++;
      if (n == 5) clear_color = 1'b0;
      wr_en = (n == 1000); wr_addr = 15'd5; wr_data = 16'h0000;
      clear_req = (n == 2000);
      n++;
      tick();
    end
    wr_en = 1'b0; clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (clear_done === 1'b1) done_cnt++;
      tick();
    end
    chk("clear_busy_cycles", 32'(n), 32'd24000);
    chk("clear_done_pulses", 32'(done_cnt), 32'd1);
    chk("clear_wr_ready_low", 32'(rdy_bad), 32'd0);
    chk("post_clear_busy", 32'(busy), 32'd0);

    add_vec(0, 0, 8'd1, 1'b1);
    add_vec(80, 0, 8'd1, 1'b1);
    add_vec(799, 479, 8'd1, 1'b1);
    add_vec(784, 479, 8'd1, 1'b1);
    add_vec(400, 240, 8'd1, 1'b1);
    add_vec(800, 0, 8'd0, 1'b0);
    add_vec(0, 480, 8'd0, 1'b0);
    add_vec(2047, 2047, 8'd0, 1'b0);
    run_vecs();

    // BPP=4 instance: nibble order within a word
    wr_en4 = 1'b1; wr_addr4 = 17'd0; wr_data4 = 16'hA5C3;
    chk("wr_ready4", 32'(wr_ready4), 32'd1);
    tick();
    wr_en4 = 1'b0;
    present(1'b1, 0, 0, 8'h3, 1'b1);
    present(1'b1, 1, 0, 8'hC, 1'b1);
    present(1'b1, 2, 0, 8'h5, 1'b1);
    present(1'b1, 3, 0, 8'hA, 1'b1);
    present(1'b1, 800, 0, 8'h0, 1'b0);
    flush();

    // Reset in the middle of a clear leaves a partially filled buffer
    write_word(15'd200, 16'h00FF);
    vga_h = 11'd0; vga_v = 11'd0;
    tick(); tick(); tick();
    chk("pre_rst_act", 32'(pixel_active), 32'd1);
    clear_color = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clear2_busy", 32'(busy), 32'd1);
    repeat (100) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(clear_done), 32'd0);
    chk("midrst_act", 32'(pixel_active), 32'd0);
    chk("midrst_pix", 32'(pixel_out), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("postrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("postrst_busy", 32'(busy), 32'd0);

    add_vec(0, 0, 8'd0, 1'b1);
    add_vec(799, 1, 8'd0, 1'b1);
    add_vec(784, 1, 8'd0, 1'b1);
    add_vec(0, 2, 8'd1, 1'b1);
    add_vec(0, 4, 8'd1, 1'b1);
    add_vec(7, 4, 8'd1, 1'b1);
    add_vec(8, 4, 8'd0, 1'b1);
    add_vec(15, 4, 8'd0, 1'b1);
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
